i2c_read_arbiter: RTL and testbench



---
 rtl/i2c_read_arbiter.sv | 149 ++++++++++++++
 tb/tb_i2c_read_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_read_arbiter.sv
// Round-robin arbiter that shares one I2C register-read engine between N requesters.
// Latches the winning request, runs the engine, and returns data/error to the winner only.
module i2c_read_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 4096,
  parameter int CW      = 13
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic [7*N-1:0]   req_worker,
  input  logic [8*N-1:0]   req_reg,
  output logic [N-1:0]     rsp_valid,
  output logic [7:0]       rsp_data,
  output logic             rsp_err,
  output logic [N-1:0]     grant,
  output logic             eng_start,
  output logic [6:0]       eng_worker,
  output logic [7:0]       eng_reg,
  output logic             eng_abort,
  input  logic             eng_busy,
  input  logic             eng_done,
  input  logic             eng_nack,
  input  logic [7:0]       eng_data
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESPOND
  } state_t;

  state_t          r_state;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_gidx;
  logic [CW-1:0]   r_cnt;
  logic [N-1:0]    r_grant;
  logic [N-1:0]    r_rsp_valid;
  logic [7:0]      r_rsp_data;
  logic            r_rsp_err;
  logic            r_eng_start;
  logic            r_eng_abort;
  logic [6:0]      r_eng_worker;
  logic [7:0]      r_eng_reg;

  logic            w_found;
  logic [PW-1:0]   w_win;
  logic [PW-1:0]   w_idx;
  logic [6:0]      w_worker;
  logic [7:0]      w_reg;

  // First set request bit searching upward from the pointer, wrapping at N-1.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_idx = PW'((32'(r_ptr) + i) % N);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_comb begin
    w_worker = '0;
    w_reg    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (w_win == PW'(i)) begin
        w_worker = req_worker[7*i +: 7];
        w_reg    = req_reg[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_gidx       <= '0;
      r_cnt        <= '0;
      r_grant      <= '0;
      r_rsp_valid  <= '0;
      r_rsp_data   <= '0;
      r_rsp_err    <= 1'b0;
      r_eng_start  <= 1'b0;
      r_eng_abort  <= 1'b0;
      r_eng_worker <= '0;
      r_eng_reg    <= '0;
    end else begin
      r_eng_start <= 1'b0;
      r_eng_abort <= 1'b0;
      r_rsp_valid <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found && !eng_busy) begin
            r_grant      <= {{(N-1){1'b0}}, 1'b1} << w_win;
            r_gidx       <= w_win;
            r_eng_worker <= w_worker;
            r_eng_reg    <= w_reg;
            r_eng_start  <= 1'b1;
            r_cnt        <= '0;
            r_state      <= S_ISSUE;
          end
        end
        // Counter holds cycles since eng_start, so abort lands TIMEOUT cycles after it.
        S_ISSUE: begin
          r_cnt   <= r_cnt + CW'(1);
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_cnt <= r_cnt + CW'(1);
          if (eng_done) begin
            r_rsp_data  <= eng_data;
            r_rsp_err   <= eng_nack;
            r_rsp_valid <= r_grant;
            r_state     <= S_RESPOND;
          end else if (r_cnt == CW'(TIMEOUT - 1)) begin
            r_eng_abort <= 1'b1;
            r_rsp_data  <= 8'h00;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= r_grant;
            r_state     <= S_RESPOND;
          end
        end
        S_RESPOND: begin
          r_grant <= '0;
          r_ptr   <= (r_gidx == PW'(N - 1)) ? '0 : r_gidx + PW'(1);
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_rsp_data;
  assign rsp_err    = r_rsp_err;
  assign grant      = r_grant;
  assign eng_start  = r_eng_start;
  assign eng_worker = r_eng_worker;
  assign eng_reg    = r_eng_reg;
  assign eng_abort  = r_eng_abort;

endmodule

// File: tb/tb_i2c_read_arbiter.sv
// Directed bench for i2c_read_arbiter (N=4, TIMEOUT=16): table of transactions plus
// hand-written busy-hold, stray-done and mid-transaction reset sequences.
module tb_i2c_read_arbiter;

  logic        clock;
  logic        reset;
  logic [3:0]  req;
  logic [27:0] req_worker;
  logic [31:0] req_reg;
  logic [3:0]  rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_err;
  logic [3:0]  grant;
  logic        eng_start;
  logic [6:0]  eng_worker;
  logic [7:0]  eng_reg;
  logic        eng_abort;
  logic        eng_busy;
  logic        eng_done;
  logic        eng_nack;
  logic [7:0]  eng_data;

  logic [6:0] wk [4] = '{7'h10, 7'h21, 7'h48, 7'h5A};
  logic [7:0] rg [4] = '{8'h01, 8'h12, 8'h0F, 8'h33};

  assign req_worker = {wk[3], wk[2], wk[1], wk[0]};
  assign req_reg    = {rg[3], rg[2], rg[1], rg[0]};

  int n_pass  = 0;
  int n_total = 0;

  i2c_read_arbiter #(.N(4), .TIMEOUT(16), .CW(5)) dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .req_worker (req_worker),
    .req_reg    (req_reg),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .grant      (grant),
    .eng_start  (eng_start),
    .eng_worker (eng_worker),
    .eng_reg    (eng_reg),
    .eng_abort  (eng_abort),
    .eng_busy   (eng_busy),
    .eng_done   (eng_done),
    .eng_nack   (eng_nack),
    .eng_data   (eng_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // dly: WAIT cycle (counted from eng_start) on which eng_done pulses; 0 = never.
  typedef struct {
    logic [3:0] rq;
    logic [3:0] rq_mid;
    int         dly;
    logic [7:0] ed;
    logic       en;
    int         g;
    logic [7:0] xd;
    logic       xe;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run_txn(input vec_t v);
    logic [3:0] oh;
    int         waited;
    int         c;
    bit         ok;
    oh     = 4'b0001 << v.g;
    req    = v.rq;
    waited = 0;
    do begin
      tick();
      waited++;
    end while (!eng_start && waited < 20);
    chk("start_latency", waited, 1);
    chk("grant", grant, oh);
    chk("eng_worker", eng_worker, wk[v.g]);
    chk("eng_reg", eng_reg, rg[v.g]);
    req = v.rq_mid;
    if (v.dly > 0) begin
      ok = 1'b1;
      repeat (v.dly) begin
        tick();
        if (eng_abort || rsp_valid != 4'b0 || grant != oh || eng_start) ok = 1'b0;
      end
      eng_done = 1'b1;
      eng_data = v.ed;
      eng_nack = v.en;
      tick();
      eng_done = 1'b0;
      eng_nack = 1'b0;
      eng_data = 8'h00;
      chk("wait_quiet", ok, 1);
    end else begin
      c = 0;
      do begin
        tick();
        c++;
      end while (!eng_abort && c < 40);
      chk("abort_cycle", c, 16);
    end
    chk("rsp_valid", rsp_valid, oh);
    chk("rsp_data", rsp_data, v.xd);
    chk("rsp_err", rsp_err, v.xe);
    chk("abort_flag", eng_abort, (v.dly == 0));
    req = req & ~oh;
    tick();
    chk("idle_clear", {rsp_valid, grant, eng_start, eng_abort}, 0);
    chk("rsp_hold", {rsp_err, rsp_data}, {v.xe, v.xd});
  endtask

  vec_t tbl [14];
  vec_t vb;
  vec_t vr;
  int   waited;
  bit   ok;

  initial begin
    tbl[0]  = '{4'b0100, 4'b0100, 1,  8'hA5, 1'b0, 2, 8'hA5, 1'b0};
    tbl[1]  = '{4'b1000, 4'b1000, 2,  8'hFF, 1'b1, 3, 8'hFF, 1'b1};
    tbl[2]  = '{4'b1111, 4'b1111, 1,  8'h11, 1'b0, 0, 8'h11, 1'b0};
    tbl[3]  = '{4'b1110, 4'b1110, 3,  8'h22, 1'b0, 1, 8'h22, 1'b0};
    tbl[4]  = '{4'b1100, 4'b1100, 2,  8'h33, 1'b0, 2, 8'h33, 1'b0};
    tbl[5]  = '{4'b1000, 4'b1000, 1,  8'h44, 1'b0, 3, 8'h44, 1'b0};
    tbl[6]  = '{4'b1001, 4'b1001, 2,  8'h55, 1'b0, 0, 8'h55, 1'b0};
    tbl[7]  = '{4'b1000, 4'b1000, 1,  8'h66, 1'b0, 3, 8'h66, 1'b0};
    tbl[8]  = '{4'b0010, 4'b0010, 0,  8'hED, 1'b0, 1, 8'h00, 1'b1};
    tbl[9]  = '{4'b0011, 4'b0011, 3,  8'h3C, 1'b0, 0, 8'h3C, 1'b0};
    tbl[10] = '{4'b0010, 4'b0010, 15, 8'h77, 1'b0, 1, 8'h77, 1'b0};
    tbl[11] = '{4'b0011, 4'b0010, 4,  8'hC3, 1'b0, 0, 8'hC3, 1'b0};
    tbl[12] = '{4'b0010, 4'b0010, 1,  8'hD4, 1'b0, 1, 8'hD4, 1'b0};
    tbl[13] = '{4'b0001, 4'b0001, 1,  8'hE5, 1'b0, 0, 8'hE5, 1'b0};
    vb      = '{4'b0010, 4'b0010, 2,  8'hB1, 1'b0, 1, 8'hB1, 1'b0};
    vr      = '{4'b0011, 4'b0011, 1,  8'h9A, 1'b0, 0, 8'h9A, 1'b0};

    reset    = 1'b1;
    req      = 4'b0;
    eng_busy = 1'b0;
    eng_done = 1'b0;
    eng_nack = 1'b0;
    eng_data = 8'h00;
    #1;
    chk("reset_state", {rsp_valid, rsp_data, rsp_err, grant, eng_start, eng_worker, eng_reg, eng_abort}, 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    tick();
    chk("idle_after_reset", {grant, eng_start, rsp_valid}, 0);

    // Engine still busy: request must be held off until eng_busy falls.
    eng_busy = 1'b1;
    req      = 4'b0010;
    ok       = 1'b1;
    repeat (5) begin
      tick();
      if (grant != 4'b0 || eng_start) ok = 1'b0;
    end
    chk("busy_hold", ok, 1);
    eng_busy = 1'b0;
    run_txn(vb);

    // Stray eng_done while idle must not produce a response or disturb held data.
    eng_done = 1'b1;
    eng_data = 8'hEE;
    eng_nack = 1'b1;
    tick();
    eng_done = 1'b0;
    eng_nack = 1'b0;
    eng_data = 8'h00;
    tick();
    chk("done_ignored", {rsp_valid, grant, eng_start, rsp_err, rsp_data}, {4'b0, 4'b0, 1'b0, 1'b0, 8'hB1});

    for (int i = 0; i < 14; i++) run_txn(tbl[i]);

    // Reset during WAIT with the pointer at 1; afterwards slot 0 must win.
    req    = 4'b0100;
    waited = 0;
    do begin
      tick();
      waited++;
    end while (!eng_start && waited < 20);
    chk("d_start", eng_start, 1);
    chk("d_grant", grant, 4'b0100);
    repeat (3) tick();
    reset = 1'b1;
    #1;
    chk("rst_outputs", {grant, rsp_valid, eng_start, eng_abort}, 0);
    chk("rst_regs", {rsp_data, rsp_err, eng_worker, eng_reg}, 0);
    req = 4'b0;
    tick();
    reset = 1'b0;
    tick();
    run_txn(vr);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
